// File: rtl/systolic_skew_feeder_pkg.sv
// tpu_feed_pkg: shared types, widths and bus helpers for the systolic skew feeder.
package tpu_feed_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    localparam int LEN_W = 8;
    localparam int CNT_W = LEN_W + 1;
    function automatic int row_lsb(input int row, input int width);
        return row * width;
    endfunction
endpackage

// File: rtl/systolic_skew_feeder_if.sv
// systolic_skew_feeder_if: controller, row-FIFO and array-edge signals of the feeder.
interface systolic_skew_feeder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS = 4,
    parameter int LEN_W = 8
) ();
    logic start;
    logic [LEN_W-1:0] len;
    logic [ROWS-1:0] fifo_empty;
    logic [ROWS-1:0] fifo_rd_en;
    logic [ROWS*DATA_WIDTH-1:0] fifo_dout;
    logic [ROWS*DATA_WIDTH-1:0] a_data;
    logic [ROWS-1:0] a_valid;
    logic array_en;
    logic busy;
    logic done;
    modport slave (
        input start, len, fifo_empty, fifo_dout,
        output fifo_rd_en, a_data, a_valid, array_en, busy, done
    );
    modport master (
        output start, len, fifo_empty, fifo_dout,
        input fifo_rd_en, a_data, a_valid, array_en, busy, done
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: drains row FIFOs into the array edge with a diagonal skew;
// any empty active row stalls the whole wavefront so the skew never breaks.
module systolic_skew_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS = 4,
    parameter int LEN_W = tpu_feed_pkg::LEN_W
) (
    input logic clk,
    input logic reset,
    systolic_skew_feeder_if.slave bus
);
    import tpu_feed_pkg::*;
    localparam int CW = LEN_W + 1;
    state_t state, state_nx;
    logic [CW-1:0] cnt, last_cnt;
    logic [LEN_W-1:0] k;
    logic [ROWS-1:0] active, rd_q;
    logic stall, stall_q, go;
    assign go = bus.start && bus.len != '0;
    assign last_cnt = CW'(k) + CW'(ROWS) - CW'(2);
    genvar i;
    for (i = 0; i < ROWS; i++) begin : g_row
        assign active[i] = state == RUN && cnt >= CW'(i) && cnt - CW'(i) < CW'(k);
        // bubbles present zero, never the stale FIFO output register
        assign bus.a_data[row_lsb(i, DATA_WIDTH) +: DATA_WIDTH] =
            rd_q[i] ? bus.fifo_dout[row_lsb(i, DATA_WIDTH) +: DATA_WIDTH] : '0;
    end
    assign stall = |(active & bus.fifo_empty);
    assign bus.fifo_rd_en = active & {ROWS{~stall}};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state == IDLE ? (go ? RUN : IDLE) :
                   state == RUN ? ((!stall && cnt == last_cnt) ? FLUSH : RUN) : IDLE;
    end
    always_comb begin
        bus.busy = state != IDLE;
        bus.done = state == FLUSH;
        bus.a_valid = rd_q;
        bus.array_en = ~stall_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            k <= '0;
            rd_q <= '0;
            stall_q <= 1'b0;
        end else begin
            rd_q <= bus.fifo_rd_en;
            stall_q <= stall;
            if (state == IDLE && go) begin
                k <= bus.len;
                cnt <= '0;
            end else if (state == RUN && !stall) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: directed checks of skew timing, stalls, bubbles and reset,
// with a behavioural model of the row FIFOs (registered data_out).
module tb_systolic_skew_feeder;
    localparam int DW = 8;
    localparam int R = 4;
    localparam int LW = 8;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    systolic_skew_feeder_if #(.DATA_WIDTH(DW), .ROWS(R), .LEN_W(LW)) bus ();
    systolic_skew_feeder #(.DATA_WIDTH(DW), .ROWS(R), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    logic [7:0] mem [R][256];
    logic [7:0] rp [R];
    logic [7:0] wp [R];
    logic [7:0] dout_r [R];
    logic [R-1:0] hold;
    logic fclr;
    logic [11:0] gcyc = '0;
    logic [11:0] t0 = '0;
    int n_pass = 0;
    int n_chk = 0;
    int under = 0;
    logic [R-1:0] rd_l [4096];
    logic [R-1:0] av_l [4096];
    logic [31:0] ad_l [4096];
    logic ae_l [4096];
    logic dn_l [4096];
    logic bz_l [4096];
    // FIFO model: one-cycle read latency, output holds the last word read
    always @(posedge clk) begin
        gcyc <= gcyc + 1'b1;
        for (int i = 0; i < R; i++) begin
            if (fclr) begin
                rp[i] <= '0;
                dout_r[i] <= 8'hEE;
            end else if (bus.fifo_rd_en[i]) begin
                if (bus.fifo_empty[i]) under <= under + 1;
                dout_r[i] <= mem[i][rp[i]];
                rp[i] <= rp[i] + 1'b1;
            end
        end
    end
    always_comb begin
        bus.fifo_empty = '0;
        bus.fifo_dout = '0;
        for (int i = 0; i < R; i++) begin
            bus.fifo_empty[i] = (rp[i] == wp[i]) | hold[i];
            bus.fifo_dout[i*DW +: DW] = dout_r[i];
        end
    end
    always @(negedge clk) begin
        rd_l[gcyc] = bus.fifo_rd_en;
        av_l[gcyc] = bus.a_valid;
        ad_l[gcyc] = bus.a_data;
        ae_l[gcyc] = bus.array_en;
        dn_l[gcyc] = bus.done;
        bz_l[gcyc] = bus.busy;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask
    task automatic fill(input int k);
        hold = '0;
        fclr = 1'b1;
        @(posedge clk);
        #1 fclr = 1'b0;
        for (int i = 0; i < R; i++) begin
            for (int j = 0; j < k; j++) mem[i][j] = 8'(10 * i + j + 1);
            wp[i] = 8'(k);
        end
    endtask
    task automatic start_k(input int k);
        @(posedge clk);
        #1 bus.start = 1'b1;
        bus.len = 8'(k);
        t0 = gcyc;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask
    // stall-free run: row i reads cycles 1+i..K+i, presents 2+i..K+1+i, done at K+ROWS
    task automatic check_run(input int k);
        logic [11:0] a;
        logic [R-1:0] er, ev;
        logic [31:0] ed;
        for (int c = 0; c <= k + 5; c++) begin
            a = t0 + 12'(c);
            er = '0;
            ev = '0;
            ed = '0;
            for (int i = 0; i < R; i++) begin
                if (c >= 1 + i && c <= k + i) er[i] = 1'b1;
                if (c >= 2 + i && c <= k + 1 + i) begin
                    ev[i] = 1'b1;
                    ed[i*8 +: 8] = 8'(10 * i + c - 2 - i + 1);
                end
            end
            chk($sformatf("k%0d rd_en c%0d", k, c), 32'(rd_l[a]), 32'(er));
            chk($sformatf("k%0d a_valid c%0d", k, c), 32'(av_l[a]), 32'(ev));
            chk($sformatf("k%0d a_data c%0d", k, c), ad_l[a], ed);
            chk($sformatf("k%0d array_en c%0d", k, c), 32'(ae_l[a]), 32'd1);
            chk($sformatf("k%0d done c%0d", k, c), 32'(dn_l[a]), (c == k + R) ? 32'd1 : 32'd0);
            chk($sformatf("k%0d busy c%0d", k, c), 32'(bz_l[a]), (c >= 1 && c <= k + R) ? 32'd1 : 32'd0);
        end
    endtask
    logic [3:0] s_rd [11] = '{4'h0, 4'h1, 4'h3, 4'h0, 4'h0, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0};
    logic [3:0] s_av [11] = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h0, 4'h0, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0};
    logic s_ae [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] s_ad [11] = '{32'h0, 32'h0, 32'h00000001, 32'h00000B02, 32'h0, 32'h0,
                               32'h00150C03, 32'h1F160D00, 32'h20170000, 32'h21000000, 32'h0};
    initial begin
        logic [11:0] a;
        bus.start = 1'b0;
        bus.len = '0;
        hold = '0;
        fclr = 1'b1;
        for (int i = 0; i < R; i++) wp[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rd_en", 32'(bus.fifo_rd_en), 32'd0);
        chk("reset a_valid", 32'(bus.a_valid), 32'd0);
        chk("reset a_data", bus.a_data, 32'd0);
        chk("reset array_en", 32'(bus.array_en), 32'd1);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        reset = 1'b1;
        fill(3);
        start_k(3);
        repeat (9) @(posedge clk);
        check_run(3);
        fill(3);
        hold = 4'b0100;
        start_k(3);
        repeat (4) @(posedge clk);
        #1 hold = '0;
        repeat (8) @(posedge clk);
        for (int c = 0; c < 11; c++) begin
            a = t0 + 12'(c);
            chk($sformatf("stall rd_en c%0d", c), 32'(rd_l[a]), 32'(s_rd[c]));
            chk($sformatf("stall a_valid c%0d", c), 32'(av_l[a]), 32'(s_av[c]));
            chk($sformatf("stall a_data c%0d", c), ad_l[a], s_ad[c]);
            chk($sformatf("stall array_en c%0d", c), 32'(ae_l[a]), 32'(s_ae[c]));
            chk($sformatf("stall done c%0d", c), 32'(dn_l[a]), (c == 9) ? 32'd1 : 32'd0);
        end
        @(posedge clk);
        #1 bus.start = 1'b1;
        bus.len = '0;
        t0 = gcyc;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        for (int c = 0; c <= 4; c++) begin
            a = t0 + 12'(c);
            chk($sformatf("len0 busy c%0d", c), 32'(bz_l[a]), 32'd0);
            chk($sformatf("len0 rd_en c%0d", c), 32'(rd_l[a]), 32'd0);
            chk($sformatf("len0 done c%0d", c), 32'(dn_l[a]), 32'd0);
        end
        fill(2);
        start_k(2);
        @(posedge clk);
        #1 bus.start = 1'b1;
        bus.len = 8'd5;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (6) @(posedge clk);
        check_run(2);
        fill(1);
        start_k(1);
        repeat (7) @(posedge clk);
        check_run(1);
        fill(3);
        start_k(3);
        @(posedge clk);
        #1 chk("pre-reset busy", 32'(bus.busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async reset rd_en", 32'(bus.fifo_rd_en), 32'd0);
        chk("async reset a_valid", 32'(bus.a_valid), 32'd0);
        chk("async reset a_data", bus.a_data, 32'd0);
        chk("async reset busy", 32'(bus.busy), 32'd0);
        chk("async reset done", 32'(bus.done), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        fill(2);
        start_k(2);
        repeat (7) @(posedge clk);
        check_run(2);
        fill(255);
        start_k(255);
        repeat (260) @(posedge clk);
        check_run(255);
        chk("fifo underflow count", 32'(under), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
